// File: rtl/program_sequencer.sv
// Program counter, branch flush and circular return stack for a two-stage fetch/execute core.
// Optional STACK_OVF_FLAG_EN adds a sticky stack_err output for push-when-full / pop-when-empty.
module program_sequencer #(
    parameter int ADDR_W      = 12,
    parameter int STACK_DEPTH = 8,
    localparam int SP_W       = $clog2(STACK_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              advance,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc,
    output logic              flush,
    output logic [SP_W:0]     stack_depth
`ifdef STACK_OVF_FLAG_EN
    ,
    output logic              stack_err
`endif
);

    localparam logic [2:0] OP_NEXT = 3'd0;
    localparam logic [2:0] OP_GOTO = 3'd1;
    localparam logic [2:0] OP_CALL = 3'd2;
    localparam logic [2:0] OP_RET  = 3'd3;
    localparam logic [2:0] OP_SKIP = 3'd4;

    localparam logic [SP_W:0] DEPTH_MAX = STACK_DEPTH[SP_W:0];

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              flush_q, flush_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [SP_W:0]     depth_q, depth_d;
    logic              push;

    // Return stack is deliberately not reset; entries are only read after being written.
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

    logic [ADDR_W-1:0] pc_inc;
    logic [SP_W-1:0]   sp_dec;

    assign pc_inc = pc_q + ADDR_W'(1);
    assign sp_dec = sp_q - SP_W'(1);

    always_comb begin
        pc_d    = pc_q;
        flush_d = flush_q;
        sp_d    = sp_q;
        depth_d = depth_q;
        push    = 1'b0;
        if (advance) begin
            // A flushed slot squashes whatever op decode presents.
            if (flush_q) begin
                pc_d    = pc_inc;
                flush_d = 1'b0;
            end else begin
                case (op)
                    OP_GOTO: begin
                        pc_d    = target;
                        flush_d = 1'b1;
                    end
                    OP_CALL: begin
                        push    = 1'b1;
                        sp_d    = sp_q + SP_W'(1);
                        if (depth_q != DEPTH_MAX) depth_d = depth_q + 1'b1;
                        pc_d    = target;
                        flush_d = 1'b1;
                    end
                    OP_RET: begin
                        pc_d    = stack_q[sp_dec];
                        sp_d    = sp_dec;
                        if (depth_q != '0) depth_d = depth_q - 1'b1;
                        flush_d = 1'b1;
                    end
                    OP_SKIP: begin
                        pc_d    = pc_inc;
                        flush_d = 1'b1;
                    end
                    default: begin
                        pc_d    = pc_inc;
                        flush_d = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= '0;
            flush_q <= 1'b0;
            sp_q    <= '0;
            depth_q <= '0;
        end else begin
            pc_q    <= pc_d;
            flush_q <= flush_d;
            sp_q    <= sp_d;
            depth_q <= depth_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) stack_q[sp_q] <= pc_q;
    end

`ifdef STACK_OVF_FLAG_EN
    logic err_q;
    logic err_set;

    assign err_set = advance && !flush_q &&
                     ((op == OP_CALL && depth_q == DEPTH_MAX) ||
                      (op == OP_RET  && depth_q == '0));

    always_ff @(posedge clk) begin
        if (reset)        err_q <= 1'b0;
        else if (err_set) err_q <= 1'b1;
    end

    assign stack_err = err_q;
`endif

    assign pc          = pc_q;
    assign flush       = flush_q;
    assign stack_depth = depth_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: reset, sequencing, branches, stack wrap, pc wrap, reset priority.
module tb_program_sequencer;

    localparam logic [2:0] OP_NEXT = 3'd0;
    localparam logic [2:0] OP_GOTO = 3'd1;
    localparam logic [2:0] OP_CALL = 3'd2;
    localparam logic [2:0] OP_RET  = 3'd3;
    localparam logic [2:0] OP_SKIP = 3'd4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        advance = 1'b0;
    logic [2:0]  op = OP_NEXT;
    logic [11:0] target = '0;
    logic [11:0] pc;
    logic        flush;
    logic [3:0]  stack_depth;
`ifdef STACK_OVF_FLAG_EN
    logic        stack_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    program_sequencer #(.ADDR_W(12), .STACK_DEPTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .advance    (advance),
        .op         (op),
        .target     (target),
        .pc         (pc),
        .flush      (flush),
        .stack_depth(stack_depth)
`ifdef STACK_OVF_FLAG_EN
        ,
        .stack_err  (stack_err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1);
    end

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic adv, input logic [2:0] o, input logic [11:0] t,
                        input logic rst = 1'b0);
        @(negedge clk);
        advance = adv;
        op      = o;
        target  = t;
        reset   = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        step(1'b1, OP_CALL, 12'h0AA, 1'b1);
        step(1'b1, OP_NEXT, 12'h000, 1'b1);
    endtask

    task automatic test_reset();
        step(1'b1, OP_GOTO, 12'h555, 1'b1);
        step(1'b1, OP_CALL, 12'h666, 1'b1);
        if ({pc, flush, stack_depth} !== {12'h000, 1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL reset: got pc=%h fl=%b d=%0d want pc=000 fl=0 d=0", pc, flush, stack_depth);
        end
        n_checks++;
`ifdef STACK_OVF_FLAG_EN
        if (stack_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_err: got %b want 0", stack_err);
        end
        n_checks++;
`endif
    endtask

    task automatic test_next();
        apply_reset();
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, OP_NEXT, 12'hABC);
            if ({pc, flush, stack_depth} !== {12'(i), 1'b0, 4'd0}) begin
                n_fail++;
                $display("FAIL next%0d: got pc=%h fl=%b d=%0d want pc=%h fl=0 d=0",
                         i, pc, flush, stack_depth, 12'(i));
            end
            n_checks++;
        end
    endtask

    task automatic test_goto_flush();
        apply_reset();
        step(1'b1, OP_GOTO, 12'h00F);
        step(1'b1, OP_NEXT, 12'h000);
        if ({pc, flush} !== {12'h010, 1'b0}) begin
            n_fail++;
            $display("FAIL goto_setup: got pc=%h fl=%b want pc=010 fl=0", pc, flush);
        end
        n_checks++;
        step(1'b1, OP_GOTO, 12'h200);
        if ({pc, flush, stack_depth} !== {12'h200, 1'b1, 4'd0}) begin
            n_fail++;
            $display("FAIL goto: got pc=%h fl=%b d=%0d want pc=200 fl=1 d=0", pc, flush, stack_depth);
        end
        n_checks++;
        step(1'b1, OP_CALL, 12'h555);
        if ({pc, flush, stack_depth} !== {12'h201, 1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL goto_flushslot: got pc=%h fl=%b d=%0d want pc=201 fl=0 d=0", pc, flush, stack_depth);
        end
        n_checks++;
    endtask

    task automatic test_hold();
        apply_reset();
        step(1'b1, OP_GOTO, 12'h123);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, OP_CALL, 12'h7FF);
            if ({pc, flush, stack_depth} !== {12'h123, 1'b1, 4'd0}) begin
                n_fail++;
                $display("FAIL hold%0d: got pc=%h fl=%b d=%0d want pc=123 fl=1 d=0", i, pc, flush, stack_depth);
            end
            n_checks++;
        end
        step(1'b1, OP_NEXT, 12'h000);
        if ({pc, flush} !== {12'h124, 1'b0}) begin
            n_fail++;
            $display("FAIL hold_release: got pc=%h fl=%b want pc=124 fl=0", pc, flush);
        end
        n_checks++;
    endtask

    task automatic test_reserved();
        for (int c = 5; c <= 7; c++) begin
            step(1'b1, 3'(c), 12'h3C3);
            if ({pc, flush, stack_depth} !== {12'(12'h124 + c - 4), 1'b0, 4'd0}) begin
                n_fail++;
                $display("FAIL reserved%0d: got pc=%h fl=%b d=%0d want pc=%h fl=0 d=0",
                         c, pc, flush, stack_depth, 12'(12'h124 + c - 4));
            end
            n_checks++;
        end
    endtask

    task automatic test_call_return();
        apply_reset();
        step(1'b1, OP_GOTO, 12'h020);
        step(1'b1, OP_NEXT, 12'h000);
        step(1'b1, OP_CALL, 12'h300);
        if ({pc, flush, stack_depth} !== {12'h300, 1'b1, 4'd1}) begin
            n_fail++;
            $display("FAIL call: got pc=%h fl=%b d=%0d want pc=300 fl=1 d=1", pc, flush, stack_depth);
        end
        n_checks++;
        step(1'b1, OP_RET, 12'h000);
        step(1'b1, OP_NEXT, 12'h000);
        step(1'b1, OP_NEXT, 12'h000);
        if ({pc, flush, stack_depth} !== {12'h303, 1'b0, 4'd1}) begin
            n_fail++;
            $display("FAIL call_body: got pc=%h fl=%b d=%0d want pc=303 fl=0 d=1", pc, flush, stack_depth);
        end
        n_checks++;
        step(1'b1, OP_RET, 12'h456);
        if ({pc, flush, stack_depth} !== {12'h021, 1'b1, 4'd0}) begin
            n_fail++;
            $display("FAIL return: got pc=%h fl=%b d=%0d want pc=021 fl=1 d=0", pc, flush, stack_depth);
        end
        n_checks++;
        step(1'b1, OP_GOTO, 12'h999);
        if ({pc, flush} !== {12'h022, 1'b0}) begin
            n_fail++;
            $display("FAIL return_flushslot: got pc=%h fl=%b want pc=022 fl=0", pc, flush);
        end
        n_checks++;
    endtask

    task automatic test_stack_wrap();
        logic [11:0] exp_ret;
        int          exp_d;
        apply_reset();
        step(1'b1, OP_NEXT, 12'h000);
        for (int k = 1; k <= 9; k++) begin
            step(1'b1, OP_CALL, 12'(k));
            exp_d = (k > 8) ? 8 : k;
            if ({pc, flush, stack_depth} !== {12'(k), 1'b1, 4'(exp_d)}) begin
                n_fail++;
                $display("FAIL push%0d: got pc=%h fl=%b d=%0d want pc=%h fl=1 d=%0d",
                         k, pc, flush, stack_depth, 12'(k), exp_d);
            end
            n_checks++;
`ifdef STACK_OVF_FLAG_EN
            if (stack_err !== (k == 9)) begin
                n_fail++;
                $display("FAIL push_err%0d: got %b want %b", k, stack_err, (k == 9));
            end
            n_checks++;
`endif
            step(1'b1, OP_NEXT, 12'h000);
            if ({pc, flush} !== {12'(k + 1), 1'b0}) begin
                n_fail++;
                $display("FAIL push_slot%0d: got pc=%h fl=%b want pc=%h fl=0", k, pc, flush, 12'(k + 1));
            end
            n_checks++;
        end
        for (int i = 0; i < 9; i++) begin
            exp_ret = (i < 8) ? 12'(9 - i) : 12'h009;
            exp_d   = (i < 8) ? 7 - i : 0;
            step(1'b1, OP_RET, 12'h000);
            if ({pc, flush, stack_depth} !== {exp_ret, 1'b1, 4'(exp_d)}) begin
                n_fail++;
                $display("FAIL pop%0d: got pc=%h fl=%b d=%0d want pc=%h fl=1 d=%0d",
                         i, pc, flush, stack_depth, exp_ret, exp_d);
            end
            n_checks++;
`ifdef STACK_OVF_FLAG_EN
            if (stack_err !== 1'b1) begin
                n_fail++;
                $display("FAIL pop_err%0d: got %b want 1", i, stack_err);
            end
            n_checks++;
`endif
            step(1'b1, OP_NEXT, 12'h000);
            if ({pc, flush} !== {exp_ret + 12'h001, 1'b0}) begin
                n_fail++;
                $display("FAIL pop_slot%0d: got pc=%h fl=%b want pc=%h fl=0", i, pc, flush, exp_ret + 12'h001);
            end
            n_checks++;
        end
`ifdef STACK_OVF_FLAG_EN
        apply_reset();
        if (stack_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear: got %b want 0", stack_err);
        end
        n_checks++;
`endif
    endtask

    task automatic test_pc_wrap_skip();
        apply_reset();
        step(1'b1, OP_GOTO, 12'hFFE);
        step(1'b1, OP_NEXT, 12'h000);
        step(1'b1, OP_NEXT, 12'h000);
        if ({pc, flush} !== {12'h000, 1'b0}) begin
            n_fail++;
            $display("FAIL pc_wrap: got pc=%h fl=%b want pc=000 fl=0", pc, flush);
        end
        n_checks++;
        step(1'b1, OP_GOTO, 12'h03F);
        step(1'b1, OP_NEXT, 12'h000);
        step(1'b1, OP_SKIP, 12'h777);
        if ({pc, flush, stack_depth} !== {12'h041, 1'b1, 4'd0}) begin
            n_fail++;
            $display("FAIL skip: got pc=%h fl=%b d=%0d want pc=041 fl=1 d=0", pc, flush, stack_depth);
        end
        n_checks++;
        step(1'b1, OP_GOTO, 12'h777);
        if ({pc, flush} !== {12'h042, 1'b0}) begin
            n_fail++;
            $display("FAIL skip_slot: got pc=%h fl=%b want pc=042 fl=0", pc, flush);
        end
        n_checks++;
    endtask

    task automatic test_reset_priority();
        apply_reset();
        step(1'b1, OP_NEXT, 12'h000);
        for (int k = 1; k <= 3; k++) begin
            step(1'b1, OP_CALL, 12'(k));
            step(1'b1, OP_NEXT, 12'h000);
        end
        if ({pc, flush, stack_depth} !== {12'h004, 1'b0, 4'd3}) begin
            n_fail++;
            $display("FAIL rstpri_setup: got pc=%h fl=%b d=%0d want pc=004 fl=0 d=3", pc, flush, stack_depth);
        end
        n_checks++;
        step(1'b1, OP_CALL, 12'h777, 1'b1);
        if ({pc, flush, stack_depth} !== {12'h000, 1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL rstpri: got pc=%h fl=%b d=%0d want pc=000 fl=0 d=0", pc, flush, stack_depth);
        end
        n_checks++;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 3'($urandom_range(0, 7)), 12'($urandom_range(0, 4095)));
            if ({pc, flush, stack_depth} !== {12'h000, 1'b0, 4'd0}) begin
                n_fail++;
                $display("FAIL idle%0d: got pc=%h fl=%b d=%0d want pc=000 fl=0 d=0", i, pc, flush, stack_depth);
            end
            n_checks++;
        end
    endtask

    initial begin
        test_reset();
        test_next();
        test_goto_flush();
        test_hold();
        test_reserved();
        test_call_return();
        test_stack_wrap();
        test_pc_wrap_skip();
        test_reset_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 Parameter ADDR_W, default 12, program-address width; it matches the flash program memory addr port.
REQ-002 Parameter STACK_DEPTH, default 8, number of hardware return-stack entries; it is a power of two.
REQ-003 Port clk  input  1  rising-edge clock.
REQ-004 Port reset  input  1  reset; synchronous, active-high.
REQ-005 Port advance  input  1  single-cycle instruction strobe, driven from the clock divisor's last phase; all state changes occur only on edges where advance=1.
REQ-006 Port op  input  3  command for the instruction executing in this slot: 0 NEXT, 1 GOTO, 2 CALL, 3 RETURN (RETURN/RETLW/RETFIE), 4 SKIP; codes 5-7 are reserved.
REQ-007 Port target  input  ADDR_W  branch destination for GOTO/CALL.
REQ-008 Port pc  output  ADDR_W  fetch address presented to flash program memory.
REQ-009 Port flush  output  1  when 1, the instruction fetched at the previous pc is executed as a NOP.
REQ-010 Port stack_depth  output  log2(STACK_DEPTH)+1  number of valid stack entries, range 0..STACK_DEPTH.

Function
REQ-011 The pc register always holds the address being fetched; the executing instruction is therefore at pc-1.
REQ-012 When advance=0, the block SHALL hold pc, flush, the stack, the stack pointer (sp) and stack_depth unchanged.
REQ-013 When advance=1 and flush=1, the block SHALL ignore op and target, set pc to pc+1, and clear flush.
REQ-014 On NEXT, or on reserved codes 5-7: pc becomes pc+1 and flush becomes 0.
REQ-015 On GOTO: pc becomes target and flush becomes 1.
REQ-016 On CALL: stack[sp] receives the current pc, sp becomes sp+1 mod STACK_DEPTH, stack_depth becomes min(stack_depth+1, STACK_DEPTH), pc becomes target, and flush becomes 1.
REQ-017 On RETURN: pc becomes stack[sp-1 mod STACK_DEPTH], sp becomes sp-1 mod STACK_DEPTH, stack_depth becomes max(stack_depth-1, 0), and flush becomes 1.
REQ-018 On SKIP: pc becomes pc+1 and flush becomes 1.
REQ-019 pc+1 SHALL wrap from 2^ADDR_W-1 to 0 with no status.
REQ-020 A push while stack_depth=STACK_DEPTH SHALL overwrite the oldest entry circularly; stack_depth remains STACK_DEPTH.
REQ-021 A pop while stack_depth=0 SHALL return the stale entry addressed by the wrapped sp; stack_depth remains 0.
REQ-022 Every branch (GOTO, CALL, RETURN) and every SKIP costs exactly one flushed slot; NEXT costs none.
REQ-023 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-024 When reset=1 at a rising clk edge: pc=0, flush=0, sp=0, stack_depth=0, regardless of advance or op.
REQ-025 Reset has priority over advance, including in the middle of a flushed slot or a CALL/RETURN edge.
REQ-026 Stack entry contents are not cleared by reset and are not observable until they are pushed.

Configuration
REQ-027 Macro STACK_OVF_FLAG_EN, when defined, adds output port stack_err (1 bit).
- stack_err is a sticky flag, set on a push with stack_depth=STACK_DEPTH or a pop with stack_depth=0.
- stack_err is cleared only by reset.
REQ-028 When STACK_OVF_FLAG_EN is undefined, the stack_err port is absent; overflow and underflow behave as in REQ-020 and REQ-021 with no indication.

Verification
REQ-029 Reset, then 5 advance pulses with op=NEXT -> pc=5, flush=0 throughout, stack_depth=0.
REQ-030 At pc=0x010, GOTO target=0x200 -> pc=0x200, flush=1; next advance with op=CALL -> op ignored, pc=0x201, flush=0, stack_depth=0.
REQ-031 At pc=0x021, CALL target=0x300; flush slot; 2 NEXT; RETURN -> pc=0x021 after RETURN, flush=1, stack_depth back to 0.
REQ-032 9 nested CALLs (pushing 0x001..0x009), then 9 RETURNs with flush slots in between -> pops 0x009..0x002, then 0x009 again; stack_depth saturates at 8 and then at 0; with STACK_OVF_FLAG_EN, stack_err=1 from the 9th CALL until reset.
REQ-033 At pc=0xFFF, NEXT -> pc=0x000; at pc=0x040, SKIP -> pc=0x041, flush=1, then the next advance -> pc=0x042, flush=0.
REQ-034 Assert reset on the same edge as advance=1 with op=CALL, stack_depth=3 -> pc=0, flush=0, stack_depth=0, no push occurs; advance=0 for 10 cycles -> all outputs unchanged.
